switch_input_conditioner: RTL and testbench



---
 rtl/switch_input_conditioner.sv | 105 ++++++++++
 tb/tb_switch_input_conditioner.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/switch_input_conditioner.sv
// -----------------------------------------------------------------------------
// switch_input_conditioner
//
// Cleans up the raw board slide switches before they reach the
// memory-mapped switch read path. Bit i of sw_stable is read back at
// address 241000+i.
//
// Each channel is handled on its own. A channel synchronises its raw input
// into the clk domain, debounces it with its own counter, and produces a
// clean level plus single-cycle rise/fall pulses.
//
// Channel map (N_SW = 21):
//   0 Inicio | 1-4 R0/R25/R75/R100 | 5-8 G0/G25/G75/G100
//   9-12 B0/B25/B75/B100 | 13-16 TD0/TD25/TD75/TD100
//   17 H | 18 V | 19 D | 20 P
//
// Parameters:
//   N_SW            number of switch channels
//   SYNC_STAGES     depth of the synchroniser chain (>= 2)
//   DEBOUNCE_CYCLES consecutive mismatching edges needed to accept a new
//                   level (>= 1); 250000 is 5 ms at 50 MHz
//
// Ports:
//   clk            system clock; all state changes on the rising edge
//   rst_n          asynchronous, active-low reset
//   sw_raw         raw asynchronous switch levels
//   sw_stable      debounced level per switch
//   sw_rise        one-cycle pulse when sw_stable[i] goes 0->1
//   sw_fall        one-cycle pulse when sw_stable[i] goes 1->0
//   sw_any_change  OR of all rise/fall pulses (combinational from registers)
// -----------------------------------------------------------------------------
module switch_input_conditioner #(
  parameter int N_SW            = 21,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_stable,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            sw_any_change
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value on which the next mismatching edge commits the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    for (genvar gi = 0; gi < N_SW; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   syn;
      logic [CNT_W-1:0]       cnt_reg;
      logic                   stable_reg;
      logic                   rise_reg;
      logic                   fall_reg;

      // Synchroniser: new samples enter at bit 0 and leave from the top bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], sw_raw[gi]};
        end
      end

      assign syn = sync_reg[SYNC_STAGES-1];

      // Debounce: any edge where the synchronised level agrees with the
      // accepted level restarts the count, so only an unbroken run of
      // DEBOUNCE_CYCLES mismatching edges gets through. The counter is
      // cleared on commit, so it never passes CNT_LAST.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
          rise_reg   <= 1'b0;
          fall_reg   <= 1'b0;
        end else begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          if (syn == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= syn;
            cnt_reg    <= '0;
            rise_reg   <= syn;
            fall_reg   <= ~syn;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
      end

      assign sw_stable[gi] = stable_reg;
      assign sw_rise[gi]   = rise_reg;
      assign sw_fall[gi]   = fall_reg;
    end
  endgenerate

  assign sw_any_change = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_switch_input_conditioner.sv
`timescale 1ns/1ps
module tb_switch_input_conditioner;

  localparam int N  = 21;
  localparam int SS = 2;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] sw_raw = '0;
  logic [N-1:0] sw_stable;
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;
  logic         sw_any_change;

  always #5 clk = ~clk;

  switch_input_conditioner #(
    .N_SW(N),
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_raw(sw_raw),
    .sw_stable(sw_stable),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .sw_any_change(sw_any_change)
  );

  // One record per stimulus window: sw_raw is applied just before the first
  // edge of the window and held for 'hold' edges. exp_first is the edge index
  // (1-based) inside the window of the first rise/fall pulse, 0 if none.
  typedef struct {
    logic [N-1:0] raw;
    int           hold;
    logic [N-1:0] exp_stable;
    int           exp_rises;
    int           exp_falls;
    int           exp_first;
    logic [N-1:0] exp_first_rise;
    logic [N-1:0] exp_first_fall;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int win_idx  = 0;
  logic [N-1:0] prev_stable = '0;

  localparam logic [N-1:0] B0  = 21'h000001;
  localparam logic [N-1:0] B1  = 21'h000002;
  localparam logic [N-1:0] B3  = 21'h000008;
  localparam logic [N-1:0] B5  = 21'h000020;
  localparam logic [N-1:0] B20 = 21'h100000;
  localparam logic [N-1:0] ALL = 21'h1FFFFF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [N-1:0] raw, input int hold,
                              input logic [N-1:0] st, input int r, input int f,
                              input int first, input logic [N-1:0] fr,
                              input logic [N-1:0] ff);
    vec_t v;
    v.raw = raw; v.hold = hold; v.exp_stable = st;
    v.exp_rises = r; v.exp_falls = f; v.exp_first = first;
    v.exp_first_rise = fr; v.exp_first_fall = ff;
    return v;
  endfunction

  // Called at posedge+1; samples once per edge for the window's length.
  task automatic run_window(input vec_t v);
    vec_t         e;
    int           rises = 0;
    int           falls = 0;
    int           first = 0;
    logic [N-1:0] first_rise = '0;
    logic [N-1:0] first_fall = '0;
    sb_q.push_back(v);
    sw_raw = v.raw;
    for (int c = 1; c <= v.hold; c++) begin
      @(posedge clk);
      #1;
      // Cycle invariants: level changes coincide with exactly one pulse kind.
      chk("stable_delta_vs_pulses", 64'(sw_stable ^ prev_stable), 64'(sw_rise | sw_fall));
      chk("rise_and_fall_overlap", 64'(sw_rise & sw_fall), 64'd0);
      chk("any_change", 64'(sw_any_change), 64'(|(sw_rise | sw_fall)));
      rises += $countones(sw_rise);
      falls += $countones(sw_fall);
      if (first == 0 && (|(sw_rise | sw_fall))) begin
        first      = c;
        first_rise = sw_rise;
        first_fall = sw_fall;
      end
      prev_stable = sw_stable;
    end
    e = sb_q.pop_front();
    chk("window_stable", 64'(sw_stable), 64'(e.exp_stable));
    chk("window_rises", 64'(rises), 64'(e.exp_rises));
    chk("window_falls", 64'(falls), 64'(e.exp_falls));
    chk("window_first_pulse_edge", 64'(first), 64'(e.exp_first));
    chk("window_first_rise_mask", 64'(first_rise), 64'(e.exp_first_rise));
    chk("window_first_fall_mask", 64'(first_fall), 64'(e.exp_first_fall));
    $display("window %0d raw=%06h hold=%0d stable=%06h rises=%0d falls=%0d first_edge=%0d",
             win_idx, v.raw, v.hold, sw_stable, rises, falls, first);
    win_idx++;
  endtask

  initial begin
    // Latency from a new level before the first window edge: pulse on edge
    // SS+DC-1+1 = 6 of the window.
    vecs.push_back(mk('0,  20, '0,  0, 0, 0, '0,  '0));  // idle after reset
    vecs.push_back(mk(B0,  10, B0,  1, 0, 6, B0,  '0));  // clean press
    vecs.push_back(mk('0,  10, '0,  0, 1, 6, '0,  B0));  // clean release
    vecs.push_back(mk(B5,   2, '0,  0, 0, 0, '0,  '0));  // bounce
    vecs.push_back(mk('0,   2, '0,  0, 0, 0, '0,  '0));
    vecs.push_back(mk(B5,   2, '0,  0, 0, 0, '0,  '0));
    vecs.push_back(mk('0,   2, '0,  0, 0, 0, '0,  '0));
    vecs.push_back(mk(B5,  10, B5,  1, 0, 6, B5,  '0));  // settle high
    vecs.push_back(mk('0,  10, '0,  0, 1, 6, '0,  B5));
    vecs.push_back(mk(ALL, 10, ALL, 21, 0, 6, ALL, '0)); // simultaneous rise
    vecs.push_back(mk('0,  10, '0,  0, 21, 6, '0, ALL)); // simultaneous fall
    vecs.push_back(mk(B3,   3, '0,  0, 0, 0, '0,  '0));  // 3-edge glitch: rejected
    vecs.push_back(mk('0,  10, '0,  0, 0, 0, '0,  '0));
    vecs.push_back(mk(B3,   4, '0,  0, 0, 0, '0,  '0));  // 4-edge pulse: accepted
    vecs.push_back(mk('0,  10, '0,  1, 1, 2, B3,  '0));  // rise lands here, then fall
    vecs.push_back(mk(B1,  10, B1,  1, 0, 6, B1,  '0));

    // Reset state
    rst_n  = 1'b0;
    sw_raw = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stable", 64'(sw_stable), 64'd0);
    chk("reset_rise", 64'(sw_rise), 64'd0);
    chk("reset_fall", 64'(sw_fall), 64'd0);
    chk("reset_any", 64'(sw_any_change), 64'd0);
    rst_n = 1'b1;
    prev_stable = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_window(vecs[i]);
    end

    // Reset mid-count: channel 1 is stable high; raise channel 20 and assert
    // reset between edges while channel 20 is still counting.
    sw_raw = B1 | B20;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_stable_async", 64'(sw_stable), 64'd0);
    chk("midreset_rise_async", 64'(sw_rise), 64'd0);
    chk("midreset_fall_async", 64'(sw_fall), 64'd0);
    chk("midreset_any_async", 64'(sw_any_change), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midreset_held", 64'(sw_stable), 64'd0);
    rst_n = 1'b1;
    // Inputs held through release count as a new level before the first
    // edge after release, so the commit lands on that edge + SS + DC - 1.
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) chk("midreset_stable_before", 64'(sw_stable), 64'd0);
      if (e == 6) begin
        chk("midreset_stable_after", 64'(sw_stable), 64'(B1 | B20));
        chk("midreset_rise_pulse", 64'(sw_rise), 64'(B1 | B20));
      end
      if (e == 7) chk("midreset_rise_cleared", 64'(sw_rise), 64'd0);
    end
    $display("reset-mid-count sequence stable=%06h", sw_stable);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
